mux_stream_sel: RTL and testbench
=================================

# mux_stream_sel

Parametrised, registered N-channel word selector with a valid/ready stream handshake. It supersedes the fixed 4×8-bit combinational selector.

- Each accepted transaction picks one channel word from a flattened input bus, by one of three modes: fixed select, round-robin, or unsigned maximum.
- The result is registered into a single-entry output stage that supports backpressure.
- Illegal requests raise a sticky error flag.
- The block sits between parallel data producers and a single downstream consumer.

## Interface
- `WIDTH`, 8: bits per channel word.
- `NUM_CH`, 4: number of channels, 2..16.
- `SEL_W`, 2: select/index width; `2**SEL_W >= NUM_CH`.

Ports:
- `clk`  in  1  rising-edge clock; the block uses one clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  `NUM_CH*WIDTH`  channel `k` occupies bits `[k*WIDTH +: WIDTH]`.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `select`  in  `SEL_W`  channel index, used in FIXED mode.
- `mode`  in  2  `00` FIXED, `01` RR, `10` MAX, `11` reserved.
- `out_data`  out  `WIDTH`  selected word.
- `out_idx`  out  `SEL_W`  channel index of `out_data`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer ready.
- `error`  out  1  sticky illegal-request flag.
- `err_clr`  in  1  synchronous clear of `error`.

## Operation
- **`in_ready` is combinational:** `in_ready = !out_valid || out_ready`. It never depends on `in_valid`.
- **Accept** means `in_valid && in_ready`. `mode` and `select` are sampled on the accept edge only.
- **FIXED mode, legal select** (`select < NUM_CH`):
  - `out_data` = channel[`select`].
  - `out_idx` = `select`.
- **RR mode:**
  - `out_data` = channel[`rr_ptr`] and `out_idx` = `rr_ptr`.
  - `rr_ptr` then increments, wrapping from `NUM_CH-1` to 0.
  - `rr_ptr` advances only on accepted RR transactions. It holds its value across mode changes and across illegal transactions.
- **MAX mode:**
  - Output is the largest unsigned channel word.
  - On a tie, the lowest index wins.
  - `out_idx` = index of the winning channel.
- **Illegal transaction:** FIXED with `select >= NUM_CH`, or mode `11`.
  - The transaction is consumed with a normal handshake.
  - No output word is produced, so `out_valid` is not set by it.
  - `error` is set on the following edge.
- **Output stage:**
  - A legal accept loads `out_data`/`out_idx` and sets `out_valid`.
  - If `out_valid && !out_ready`, the outputs hold stable.
  - If `out_valid && out_ready` with no new legal accept, `out_valid` clears.
  - If `out_valid && out_ready` with a new legal accept in the same cycle, the new word loads and `out_valid` stays 1 (back-to-back, 1 word/cycle).
- **Error flag:**
  - `error` stays set until `err_clr`.
  - If an illegal accept and `err_clr` occur in the same cycle, set wins and `error` = 1.
- **State:** the stage is EMPTY (`out_valid`=0) or FULL (`out_valid`=1).
  - EMPTY→FULL on a legal accept.
  - FULL→EMPTY on `out_ready` with no legal accept.
  - FULL→FULL on a stall, or on drain plus a legal accept.

## Timing
- **Latency:** output appears 1 cycle after accept. A word accepted at edge N is visible after edge N, with `out_valid`=1 in cycle N+1.
- **Throughput:** 1 transaction/cycle when `out_ready` is held high.
- **Reset values:**
  - `out_data`=0, `out_idx`=0, `out_valid`=0, `error`=0, `rr_ptr`=0.
  - `in_ready`=1 during and after reset.
- **Reset is asynchronous:** asserting `rst_n` low mid-transfer clears all state immediately. Any held output word is dropped.
- **No combinational paths** from `in_data`, `select` or `mode` to any output.

## Configuration
- **`MUX_STREAM_MAX_MODE_EN` defined:**
  - MAX mode (`10`) is implemented as described above.
  - The comparator tree over all `NUM_CH` channels is built.
- **`MUX_STREAM_MAX_MODE_EN` not defined:**
  - No comparator logic is built.
  - Mode `10` is treated exactly like reserved mode `11`: the transaction is consumed, no output is produced, and `error` is set.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → all outputs 0 and `in_ready`=1.
- **FIXED sweep:** `in_data` = {8'h44, 8'h33, 8'h22, 8'h11}, FIXED, `select` 0..3 back-to-back, `out_ready`=1 → `out_data` 11, 22, 33, 44 with `out_idx` 0..3, one cycle after each accept, `out_valid` continuous.
- **RR wrap with mode interruption:** same data, 6 RR accepts with one FIXED `select`=2 inserted after the 3rd → RR outputs 11, 22, 33, 44, 11, 22, and the FIXED output 33. Confirms `rr_ptr` is untouched by the FIXED transaction.
- **Backpressure:** hold `out_ready`=0 for 4 cycles after one legal accept → `out_data` stable, `in_ready`=0, no further accepts. Then raise `out_ready` with `in_valid`=1 → drain and new load in the same cycle.
- **Error path:** `NUM_CH`=3, `SEL_W`=2, FIXED `select`=3 → `in_ready` handshake completes, `out_valid` stays 0, `error`=1 next cycle. Then the same illegal request concurrent with `err_clr` → `error` remains 1. Then `err_clr` alone → `error`=0.
- **MAX mode:** `in_data` = {8'h7F, 8'h80, 8'h80, 8'h05}, MAX →
  - macro defined: `out_data`=80, `out_idx`=1 (lowest index on tie).
  - macro undefined: no output, `error`=1.

Source files
------------

// File: rtl/mux_stream_sel.sv
// Registered N-channel word selector (FIXED / RR / MAX) with a one-entry valid/ready output stage.
// Optional MAX mode is built only when MUX_STREAM_MAX_MODE_EN is defined; otherwise mode 10 is illegal.
module mux_stream_sel #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        select,
   input  logic [1:0]              mode,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_idx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    error,
   input  logic                    err_clr
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e           st_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [SEL_W-1:0] rr_q;
   logic             err_q;
   logic             legal, accept, sel_ok;
   logic [WIDTH-1:0] fix_w, rr_w;

   // Extra bit so NUM_CH == 2**SEL_W compares correctly
   assign sel_ok = ({1'b0, select} < (SEL_W+1)'(NUM_CH));

   always_comb begin
      fix_w = '0;
      rr_w  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (select == SEL_W'(k)) fix_w = in_data[k*WIDTH +: WIDTH];
         if (rr_q   == SEL_W'(k)) rr_w  = in_data[k*WIDTH +: WIDTH];
      end
   end

`ifdef MUX_STREAM_MAX_MODE_EN
   logic [WIDTH-1:0] max_w;
   logic [SEL_W-1:0] max_i;

   // Strict greater-than keeps the lowest index on ties
   always_comb begin
      max_w = in_data[WIDTH-1:0];
      max_i = '0;
      for (int k = 1; k < NUM_CH; k++) begin
         if (in_data[k*WIDTH +: WIDTH] > max_w) begin
            max_w = in_data[k*WIDTH +: WIDTH];
            max_i = SEL_W'(k);
         end
      end
   end
`endif

   always_comb begin
      legal  = 1'b0;
      data_d = data_q;
      idx_d  = idx_q;
      case (mode)
         2'b00: begin
            legal  = sel_ok;
            data_d = fix_w;
            idx_d  = select;
         end
         2'b01: begin
            legal  = 1'b1;
            data_d = rr_w;
            idx_d  = rr_q;
         end
`ifdef MUX_STREAM_MAX_MODE_EN
         2'b10: begin
            legal  = 1'b1;
            data_d = max_w;
            idx_d  = max_i;
         end
`endif
         default: legal = 1'b0;
      endcase
   end

   assign in_ready = (st_q == EMPTY) || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= EMPTY;
         data_q <= '0;
         idx_q  <= '0;
         rr_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept && legal) begin
            st_q   <= FULL;
            data_q <= data_d;
            idx_q  <= idx_d;
         end else if (out_ready) begin
            st_q   <= EMPTY;
         end
         if (accept && mode == 2'b01)
            rr_q <= (rr_q == SEL_W'(NUM_CH-1)) ? '0 : rr_q + SEL_W'(1);
         // Set has priority over a same-cycle clear
         if (accept && !legal) err_q <= 1'b1;
         else if (err_clr)     err_q <= 1'b0;
      end
   end

   assign out_valid = (st_q == FULL);
   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign error     = err_q;

endmodule

// File: tb/tb_mux_stream_sel.sv
// Bench for mux_stream_sel: a 4-channel and a 3-channel instance share stimulus and are checked
// each cycle against a transaction-level model, plus literal expectations on key vectors.
module tb_mux_stream_sel;

`ifdef MUX_STREAM_MAX_MODE_EN
   localparam bit MAXEN = 1'b1;
`else
   localparam bit MAXEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = 32'h4433_2211;
   logic        in_valid = 1'b0;
   logic [1:0]  select = 2'd0;
   logic [1:0]  mode = 2'd0;
   logic        out_ready = 1'b1;
   logic        err_clr = 1'b0;

   logic       r4, v4, e4, r3, v3, e3;
   logic [7:0] d4, d3;
   logic [1:0] i4, i3;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   mux_stream_sel #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(r4),
      .select(select), .mode(mode), .out_data(d4), .out_idx(i4), .out_valid(v4),
      .out_ready(out_ready), .error(e4), .err_clr(err_clr));

   mux_stream_sel #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_valid(in_valid), .in_ready(r3),
      .select(select), .mode(mode), .out_data(d3), .out_idx(i3), .out_valid(v3),
      .out_ready(out_ready), .error(e3), .err_clr(err_clr));

   // Model state per instance (0: 4 channels, 1: 3 channels)
   logic       m_ov[2];
   logic [7:0] m_od[2];
   int         m_oi[2];
   logic       m_err[2];
   int         m_rr[2];

   function automatic int chw(input int k);
      return int'(in_data[k*8 +: 8]);
   endfunction

   // Channel chosen by the current request, or -1 if the request is illegal
   function automatic int pick(input int i);
      int n = (i == 0) ? 4 : 3;
      int x = 0;
      if (mode == 2'd0) return (int'(select) < n) ? int'(select) : -1;
      if (mode == 2'd1) return m_rr[i];
      if (mode == 2'd2 && MAXEN) begin
         for (int k = 1; k < n; k++) if (chw(k) > chw(x)) x = k;
         return x;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_ov[i] <= 1'b0; m_od[i] <= 8'd0; m_oi[i] <= 0; m_err[i] <= 1'b0; m_rr[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (in_valid && (!m_ov[i] || out_ready)) begin
               if (pick(i) >= 0) begin
                  m_ov[i] <= 1'b1;
                  m_od[i] <= 8'(chw(pick(i)));
                  m_oi[i] <= pick(i);
               end else begin
                  if (out_ready) m_ov[i] <= 1'b0;
                  m_err[i] <= 1'b1;
               end
               if (mode == 2'd1) m_rr[i] <= (m_rr[i] + 1) % ((i == 0) ? 4 : 3);
            end else begin
               if (out_ready) m_ov[i] <= 1'b0;
            end
            if (err_clr && !(in_valid && (!m_ov[i] || out_ready) && pick(i) < 0))
               m_err[i] <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("in_ready4", int'(r4), int'(!m_ov[0] || out_ready));
      chk("out_valid4", int'(v4), int'(m_ov[0]));
      chk("out_data4", int'(d4), int'(m_od[0]));
      chk("out_idx4", int'(i4), m_oi[0]);
      chk("error4", int'(e4), int'(m_err[0]));
      chk("in_ready3", int'(r3), int'(!m_ov[1] || out_ready));
      chk("out_valid3", int'(v3), int'(m_ov[1]));
      chk("out_data3", int'(d3), int'(m_od[1]));
      chk("out_idx3", int'(i3), m_oi[1]);
      chk("error3", int'(e3), int'(m_err[1]));
   end

   task automatic cyc(input logic v, input logic [1:0] md, input logic [1:0] s,
                      input logic ordy, input logic clr);
      in_valid = v; mode = md; select = s; out_ready = ordy; err_clr = clr;
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(r4), 1);
      chk("rst_out_valid", int'(v4), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_data", int'(d4), 0);
      chk("post_rst_idx", int'(i4), 0);
      chk("post_rst_err", int'(e4), 0);
      chk("post_rst_ready", int'(r4), 1);

      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 2'd0, 2'(k), 1'b1, 1'b0);
         chk("fixed_data", int'(d4), 'h11 * (k + 1));
         chk("fixed_idx", int'(i4), k);
         chk("fixed_valid", int'(v4), 1);
      end

      cyc(1'b1, 2'd1, 2'd0, 1'b1, 1'b0); chk("rr0", int'(d4), 'h11);
      cyc(1'b1, 2'd1, 2'd0, 1'b1, 1'b0); chk("rr1", int'(d4), 'h22);
      cyc(1'b1, 2'd1, 2'd0, 1'b1, 1'b0); chk("rr2", int'(d4), 'h33);
      cyc(1'b1, 2'd0, 2'd2, 1'b1, 1'b0); chk("rr_fixed", int'(d4), 'h33);
      cyc(1'b1, 2'd1, 2'd0, 1'b1, 1'b0); chk("rr3", int'(d4), 'h44); chk("rr3_idx", int'(i4), 3);
      cyc(1'b1, 2'd1, 2'd0, 1'b1, 1'b0); chk("rr_wrap", int'(d4), 'h11); chk("rr_wrap_idx", int'(i4), 0);
      cyc(1'b1, 2'd1, 2'd0, 1'b1, 1'b0); chk("rr5", int'(d4), 'h22);
      chk("rr_no_err", int'(e4), 0);
      cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b1); chk("idle_valid", int'(v4), 0);

      cyc(1'b1, 2'd0, 2'd1, 1'b0, 1'b0); chk("bp_load", int'(d4), 'h22);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
         chk("bp_hold", int'(d4), 'h22);
         chk("bp_ready", int'(r4), 0);
         chk("bp_valid", int'(v4), 1);
      end
      cyc(1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
      chk("bp_reload", int'(d4), 'h33); chk("bp_reload_v", int'(v4), 1);
      cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b0); chk("bp_drain", int'(v4), 0);

      cyc(1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
      chk("rsv_valid", int'(v4), 0); chk("rsv_err", int'(e4), 1);
      cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b1); chk("clr4", int'(e4), 0);
      cyc(1'b1, 2'd0, 2'd3, 1'b1, 1'b0);
      chk("ill3_valid", int'(v3), 0); chk("ill3_err", int'(e3), 1); chk("leg4_data", int'(d4), 'h44);
      cyc(1'b1, 2'd0, 2'd3, 1'b1, 1'b1); chk("set_wins", int'(e3), 1);
      cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b1); chk("clr3", int'(e3), 0);

      in_data = 32'h7F80_8005;
      cyc(1'b1, 2'd2, 2'd0, 1'b1, 1'b0);
      if (MAXEN) begin
         chk("max_data", int'(d4), 'h80); chk("max_idx", int'(i4), 1); chk("max_err", int'(e4), 0);
      end else begin
         chk("max_valid", int'(v4), 0); chk("max_err", int'(e4), 1);
      end
      cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b1);

      cyc(1'b1, 2'd0, 2'd1, 1'b0, 1'b0); chk("pre_rst_valid", int'(v4), 1);
      rst_n = 1'b0; #1;
      chk("async_rst_valid", int'(v4), 0);
      chk("async_rst_data", int'(d4), 0);
      chk("async_rst_ready", int'(r4), 1);
      @(posedge clk); #1; rst_n = 1'b1;
      cyc(1'b1, 2'd1, 2'd0, 1'b1, 1'b0); chk("rr_after_rst", int'(i4), 0);
      cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
